temporal_equal_n: RTL and testbench
===================================

Name: temporal_equal_n

Overview:
- Parametrised successor to the 2-input pulse-width "equal" race-logic primitive.
- Takes N_IN pulse-width coded spikes within one gamma cycle. Fires one output pulse of PULSE_WIDTH cycles when all inputs arrive within TOL cycles of each other.
- Reports the firing time and flags early rejection.
- Sits in the temporal-logic layer beside min/max/inhibit, and is driven by the shared gamma sequencer.

Parameters:
- N_IN, 2, number of input channels (>=2)
- GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle
- PULSE_WIDTH, 8, output pulse length in aclk cycles (1..GAMMA_CYCLE_WIDTH-1)
- TOL, 0, maximum allowed spread (tmax - tmin) in cycles for a match
- TW, $clog2(GAMMA_CYCLE_WIDTH), time field width (derived; do not override)

Ports:
- aclk  in  1  clock
- grst_n  in  1  asynchronous active-low reset
- gclr  in  1  synchronous active-high start-of-gamma pulse
- in  in  N_IN  spike inputs; rising edge = arrival
- y  out  1  match pulse
- t_out  out  TW  arrival time of the latest input (tmax), valid while y=1
- rej  out  1  level: this gamma cycle rejected (spread exceeded TOL)

Behaviour:
- Async reset (grst_n=0): y=0, rej=0, t_out=0, g_cnt=0, all arr_v=0, in_q=0, FSM state=WAIT. Effect is immediate, not clocked.
- Gamma counter g_cnt (TW bits):
  - On gclr, loads 0.
  - Otherwise increments each cycle, saturating at GAMMA_CYCLE_WIDTH-1 (no wrap).
- Arrival capture, per channel i, at each posedge:
  - in_q[i] <= in[i].
  - Rise = in[i] & ~in_q[i].
  - First rise while arr_v[i]=0 sets arr_v[i]=1 and arr_t[i]=g_cnt.
  - Later rises in the same gamma cycle are ignored.
- gclr, at its posedge:
  - Clears arr_v and loads in_q from in. An input already high at gclr is not an arrival; it must fall and rise again.
  - gclr has priority over any arrival sampled in the same cycle.
- FSM states: WAIT, FIRE, DONE.
  - WAIT: evaluate on the edge, including arrivals captured on that same edge.
    - all_v (every arr_v set) and tmax-tmin <= TOL -> FIRE. y<=1, t_out<=tmax, pulse counter<=PULSE_WIDTH-1.
    - all_v and tmax-tmin > TOL -> DONE, rej<=1.
    - Early reject: any arr_v set, not all_v, and g_cnt - tmin > TOL -> DONE, rej<=1. No need to wait for the laggard.
    - g_cnt saturated with not all_v -> DONE, rej=0 (silent miss).
  - FIRE: y held 1 while the counter decrements. At 0 -> DONE, y<=0. y is high for exactly PULSE_WIDTH cycles.
  - DONE: hold y=0 and rej until gclr.
  - gclr in any state -> WAIT, y<=0, rej<=0, t_out unchanged. A pulse in progress is truncated on that edge.
- Latency: y rises on the posedge that samples the final qualifying rise, so it is visible 1 cycle after the input edge. Simultaneous arrivals on all channels give a spread of 0, which always matches.
- Arithmetic:
  - tmin/tmax: unsigned TW-bit reduction over arrived channels only.
  - g_cnt - tmin: never negative, since tmin <= g_cnt.
  - Compare against TOL at TW+1 bits so TOL >= GAMMA never overflows.
- At most one output pulse per gamma cycle.

Decomposition:
- Package temporal_pkg:
  - eq_state_t enum {WAIT, FIRE, DONE}
  - time_t typedef logic [TW-1:0]
  - function for min/max reduction over an arrival-valid mask
  - shared GAMMA_CYCLE_WIDTH/PULSE_WIDTH defaults used by the sibling temporal primitives
- Sub-module arrival_capture: one instance per channel, generated N_IN times. Holds in_q, arr_v and arr_t, with gclr clear and first-edge latch.
- Top level holds g_cnt, the min/max reduction, the FSM and the pulse counter.

Test Plan (GAMMA=16, PW=8, N_IN=2 unless stated; times in cycles after gclr):
- a and b rise together at t=2, TOL=0 -> y high cycles 3..10 (8 cycles), t_out=2, rej=0.
- a rises at t=2, b at t=4, TOL=0 -> rej=1 from cycle 4 (early reject at g_cnt=3 edge), y never rises.
- Same stimulus with TOL=2 -> y high for 8 cycles starting cycle 5, t_out=4, rej=0.
- Only a rises, at t=2, TOL=15 -> y=0 and rej=0 for the whole gamma cycle. Next gclr returns to WAIT with rej=0.
- Matched pulse at t=2, gclr at t=6 -> y drops on the gclr edge (4-cycle pulse). Inputs held high across gclr produce no new arrival.
- N_IN=3, TOL=1, arrivals at t=5,6,6 -> y for 8 cycles, t_out=6. Then grst_n=0 mid-pulse -> y=0 immediately (async), all outputs at reset values.

Source files
------------

// File: rtl/temporal_pkg.sv
`default_nettype none
// ============================================================================
// Module   : temporal_pkg
// Brief    : Shared types, defaults and helpers for the temporal-logic layer.
// Revision : 1.0 - initial release
// ============================================================================
package temporal_pkg;

    localparam int c_gamma_cycle_width = 16;
    localparam int c_pulse_width       = 8;
    localparam int c_tw                = $clog2(c_gamma_cycle_width);

    // Upper bounds accepted by masked_reduce: 32 channels, 8-bit times (gamma <= 256).
    localparam int c_max_in = 32;
    localparam int c_max_tw = 8;

    typedef logic [c_tw-1:0] time_t;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        FIRE = 2'd1,
        DONE = 2'd2
    } eq_state_t;

    function automatic logic [c_max_tw-1:0] masked_reduce(
        input logic [c_max_in-1:0]          mask,
        input logic [c_max_in*c_max_tw-1:0] times,
        input logic                         want_max
    );
        logic [c_max_tw-1:0] acc;
        logic [c_max_tw-1:0] cur;
        acc = want_max ? '0 : '1;
        for (int i = 0; i < c_max_in; i++) begin
            cur = times[i*c_max_tw +: c_max_tw];
            if (mask[i] && (want_max ? (cur > acc) : (cur < acc))) begin
                acc = cur;
            end
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arrival_capture.sv
`default_nettype none
// ============================================================================
// Module   : arrival_capture
// Brief    : Per-channel first-rising-edge latch with gamma-cycle clear.
// Revision : 1.0 - initial release
// ============================================================================
module arrival_capture #(
    parameter int TW = 4
) (
    input  logic          aclk,
    input  logic          grst_n,
    input  logic          gclr,
    input  logic          i_in,
    input  logic [TW-1:0] i_g_cnt,
    output logic          o_arr_v,
    output logic [TW-1:0] o_arr_t
);

    logic          r_in_q;
    logic          r_arr_v;
    logic [TW-1:0] r_arr_t;
    logic          w_rise;
    logic          w_take;

    // Outputs are the post-edge view so the evaluator sees arrivals sampled this cycle.
    assign w_rise  = i_in & ~r_in_q;
    assign w_take  = ~gclr & w_rise & ~r_arr_v;
    assign o_arr_v = ~gclr & (r_arr_v | w_rise);
    assign o_arr_t = w_take ? i_g_cnt : r_arr_t;

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            r_in_q  <= 1'b0;
            r_arr_v <= 1'b0;
            r_arr_t <= '0;
        end else begin
            r_in_q  <= i_in;
            r_arr_v <= o_arr_v;
            r_arr_t <= o_arr_t;
        end
    end

endmodule
`default_nettype wire

// File: rtl/temporal_equal_n.sv
`default_nettype none
// ============================================================================
// Module   : temporal_equal_n
// Brief    : N-input race-logic "equal": fires when all arrivals are within TOL.
// Revision : 1.0 - initial release
// ============================================================================
module temporal_equal_n
    import temporal_pkg::*;
#(
    parameter int N_IN              = 2,
    parameter int GAMMA_CYCLE_WIDTH = c_gamma_cycle_width,
    parameter int PULSE_WIDTH       = c_pulse_width,
    parameter int TOL               = 0,
    parameter int TW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic            aclk,
    input  logic            grst_n,
    input  logic            gclr,
    input  logic [N_IN-1:0] in,
    output logic            y,
    output logic [TW-1:0]   t_out,
    output logic            rej
);

    localparam logic [TW-1:0] c_g_max     = TW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [TW-1:0] c_pw_load   = TW'(PULSE_WIDTH - 1);
    localparam int            c_tol_lim   = (1 << (TW + 1)) - 1;
    localparam logic [TW:0]   c_tol       = (TOL > c_tol_lim) ? (TW+1)'(c_tol_lim)
                                                              : (TW+1)'(TOL);

    logic [TW-1:0]              r_g_cnt;
    logic [N_IN-1:0]            w_arr_v;
    logic [N_IN-1:0][TW-1:0]    w_arr_t;
    logic [c_max_in-1:0]        w_mask_ext;
    logic [c_max_in*c_max_tw-1:0] w_times_ext;
    logic [TW-1:0]              w_tmin;
    logic [TW-1:0]              w_tmax;
    logic [TW:0]                w_spread;
    logic [TW:0]                w_age;
    logic                       w_all_v;
    logic                       w_any_v;
    logic                       w_match;
    logic                       w_mismatch;
    logic                       w_early;
    logic                       w_miss;

    eq_state_t                  r_state;
    eq_state_t                  w_state_nxt;
    logic [TW-1:0]              r_pcnt;
    logic [TW-1:0]              w_pcnt_nxt;
    logic                       w_y_nxt;
    logic                       w_rej_nxt;
    logic [TW-1:0]              w_t_out_nxt;

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            r_g_cnt <= '0;
        end else if (gclr) begin
            r_g_cnt <= '0;
        end else if (r_g_cnt != c_g_max) begin
            r_g_cnt <= r_g_cnt + TW'(1);
        end
    end

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_chan
        arrival_capture #(
            .TW(TW)
        ) u_cap (
            .aclk    (aclk),
            .grst_n  (grst_n),
            .gclr    (gclr),
            .i_in    (in[gi]),
            .i_g_cnt (r_g_cnt),
            .o_arr_v (w_arr_v[gi]),
            .o_arr_t (w_arr_t[gi])
        );
    end

    always_comb begin
        w_times_ext = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_times_ext[i*c_max_tw +: c_max_tw] = c_max_tw'(w_arr_t[i]);
        end
    end

    assign w_mask_ext = c_max_in'(w_arr_v);
    assign w_tmin     = TW'(masked_reduce(w_mask_ext, w_times_ext, 1'b0));
    assign w_tmax     = TW'(masked_reduce(w_mask_ext, w_times_ext, 1'b1));

    // One extra bit keeps the TOL comparison exact for any TOL value.
    assign w_spread   = {1'b0, w_tmax} - {1'b0, w_tmin};
    assign w_age      = {1'b0, r_g_cnt} - {1'b0, w_tmin};
    assign w_all_v    = &w_arr_v;
    assign w_any_v    = |w_arr_v;
    assign w_match    = w_all_v & (w_spread <= c_tol);
    assign w_mismatch = w_all_v & (w_spread > c_tol);
    assign w_early    = ~w_all_v & w_any_v & (w_age > c_tol);
    assign w_miss     = ~w_all_v & (r_g_cnt == c_g_max);

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            r_state <= WAIT;
            r_pcnt  <= '0;
            y       <= 1'b0;
            rej     <= 1'b0;
            t_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pcnt  <= w_pcnt_nxt;
            y       <= w_y_nxt;
            rej     <= w_rej_nxt;
            t_out   <= w_t_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (gclr) begin
            w_state_nxt = WAIT;
        end else begin
            case (r_state)
                WAIT: begin
                    if (w_match) begin
                        w_state_nxt = FIRE;
                    end else if (w_mismatch || w_early || w_miss) begin
                        w_state_nxt = DONE;
                    end
                end
                FIRE: begin
                    if (r_pcnt == '0) begin
                        w_state_nxt = DONE;
                    end
                end
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = WAIT;
            endcase
        end
    end

    always_comb begin
        w_y_nxt     = y;
        w_rej_nxt   = rej;
        w_t_out_nxt = t_out;
        w_pcnt_nxt  = r_pcnt;
        if (gclr) begin
            w_y_nxt   = 1'b0;
            w_rej_nxt = 1'b0;
        end else begin
            case (r_state)
                WAIT: begin
                    if (w_match) begin
                        w_y_nxt     = 1'b1;
                        w_t_out_nxt = w_tmax;
                        w_pcnt_nxt  = c_pw_load;
                    end else if (w_mismatch || w_early) begin
                        w_rej_nxt = 1'b1;
                    end
                end
                FIRE: begin
                    if (r_pcnt == '0) begin
                        w_y_nxt = 1'b0;
                    end else begin
                        w_pcnt_nxt = r_pcnt - TW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_temporal_equal_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_temporal_equal_n
// Brief    : Four parameterisations driven by one stimulus, checked per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_temporal_equal_n;

    localparam int MAXL = 32;
    localparam int ND   = 4;
    localparam int PW   = 8;

    logic       aclk   = 1'b0;
    logic       grst_n = 1'b0;
    logic       gclr   = 1'b0;
    logic [2:0] stim   = '0;
    logic       y_w   [ND];
    logic       rej_w [ND];
    logic [3:0] t_w   [ND];

    int nch  [ND] = '{2, 2, 2, 3};
    int tolv [ND] = '{0, 2, 15, 1};

    logic       s      [3][MAXL];
    logic       ob_y   [ND][MAXL];
    logic       ob_rej [ND][MAXL];
    logic [3:0] ob_t   [ND][MAXL];
    int         last_t [ND] = '{0, 0, 0, 0};
    int         n_vec = 0;
    int         n_err = 0;

    always #5 aclk = ~aclk;

    temporal_equal_n #(.N_IN(2), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .TOL(0)) u_dut0 (
        .aclk(aclk), .grst_n(grst_n), .gclr(gclr), .in(stim[1:0]),
        .y(y_w[0]), .t_out(t_w[0]), .rej(rej_w[0]));
    temporal_equal_n #(.N_IN(2), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .TOL(2)) u_dut1 (
        .aclk(aclk), .grst_n(grst_n), .gclr(gclr), .in(stim[1:0]),
        .y(y_w[1]), .t_out(t_w[1]), .rej(rej_w[1]));
    temporal_equal_n #(.N_IN(2), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .TOL(15)) u_dut2 (
        .aclk(aclk), .grst_n(grst_n), .gclr(gclr), .in(stim[1:0]),
        .y(y_w[2]), .t_out(t_w[2]), .rej(rej_w[2]));
    temporal_equal_n #(.N_IN(3), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .TOL(1)) u_dut3 (
        .aclk(aclk), .grst_n(grst_n), .gclr(gclr), .in(stim),
        .y(y_w[3]), .t_out(t_w[3]), .rej(rej_w[3]));

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_stim();
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < MAXL; k++)
                s[c][k] = 1'b0;
    endtask

    task automatic set_pulse(input int c, input int from, input int to);
        for (int k = from; k <= to && k < MAXL; k++) s[c][k] = 1'b1;
    endtask

    // Edge 0 carries gclr; observation index k is the cycle following edge k.
    task automatic drive_gamma(input int len);
        for (int k = 0; k < len; k++) begin
            @(negedge aclk);
            gclr = (k == 0);
            stim = {s[2][k], s[1][k], s[0][k]};
            @(posedge aclk);
            #1;
            for (int d = 0; d < ND; d++) begin
                ob_y[d][k]   = y_w[d];
                ob_rej[d][k] = rej_w[d];
                ob_t[d][k]   = t_w[d];
            end
        end
    endtask

    function automatic int count_y(input int d, input int len);
        int n = 0;
        for (int k = 0; k < len; k++) if (ob_y[d][k]) n++;
        return n;
    endfunction

    function automatic int count_rej(input int d, input int len);
        int n = 0;
        for (int k = 0; k < len; k++) if (ob_rej[d][k]) n++;
        return n;
    endfunction

    function automatic int first_y(input int d, input int len);
        for (int k = 0; k < len; k++) if (ob_y[d][k]) return k;
        return -1;
    endfunction

    task automatic test_reset();
        grst_n = 1'b0;
        #12;
        for (int d = 0; d < ND; d++) begin
            n_vec += 3;
            if (y_w[d] !== 1'b0) begin n_err++; $display("FAIL reset_y d%0d got %b exp 0", d, y_w[d]); end
            if (rej_w[d] !== 1'b0) begin n_err++; $display("FAIL reset_rej d%0d got %b exp 0", d, rej_w[d]); end
            if (t_w[d] !== 4'd0) begin n_err++; $display("FAIL reset_t d%0d got %0d exp 0", d, t_w[d]); end
        end
        @(negedge aclk);
        grst_n = 1'b1;
    endtask

    task automatic test_simultaneous();
        clear_stim();
        set_pulse(0, 3, 8); set_pulse(1, 3, 8); set_pulse(2, 3, 8);
        drive_gamma(20);
        n_vec += 4;
        if (first_y(0, 20) !== 3) begin n_err++; $display("FAIL sim_first d0 got %0d exp 3", first_y(0, 20)); end
        if (count_y(0, 20) !== 8) begin n_err++; $display("FAIL sim_width d0 got %0d exp 8", count_y(0, 20)); end
        if (ob_t[0][3] !== 4'd2) begin n_err++; $display("FAIL sim_tout d0 got %0d exp 2", ob_t[0][3]); end
        if (count_rej(0, 20) !== 0) begin n_err++; $display("FAIL sim_rej d0 got %0d exp 0", count_rej(0, 20)); end
    endtask

    task automatic test_early_reject();
        clear_stim();
        set_pulse(0, 3, 10); set_pulse(1, 5, 10);
        drive_gamma(20);
        n_vec += 6;
        if (ob_rej[0][3] !== 1'b0) begin n_err++; $display("FAIL early_pre d0 got %b exp 0", ob_rej[0][3]); end
        if (ob_rej[0][4] !== 1'b1) begin n_err++; $display("FAIL early_rej d0 got %b exp 1", ob_rej[0][4]); end
        if (count_y(0, 20) !== 0) begin n_err++; $display("FAIL early_y d0 got %0d exp 0", count_y(0, 20)); end
        if (first_y(1, 20) !== 5) begin n_err++; $display("FAIL tol2_first d1 got %0d exp 5", first_y(1, 20)); end
        if (count_y(1, 20) !== 8) begin n_err++; $display("FAIL tol2_width d1 got %0d exp 8", count_y(1, 20)); end
        if (ob_t[1][5] !== 4'd4) begin n_err++; $display("FAIL tol2_tout d1 got %0d exp 4", ob_t[1][5]); end
    endtask

    task automatic test_silent_miss();
        clear_stim();
        set_pulse(0, 3, 10);
        drive_gamma(20);
        n_vec += 2;
        if (count_y(2, 20) !== 0) begin n_err++; $display("FAIL miss_y d2 got %0d exp 0", count_y(2, 20)); end
        if (count_rej(2, 20) !== 0) begin n_err++; $display("FAIL miss_rej d2 got %0d exp 0", count_rej(2, 20)); end
        clear_stim();
        set_pulse(0, 2, 6); set_pulse(1, 2, 6);
        drive_gamma(16);
        n_vec += 2;
        if (ob_rej[2][0] !== 1'b0) begin n_err++; $display("FAIL miss_next_rej d2 got %b exp 0", ob_rej[2][0]); end
        if (first_y(2, 16) !== 2) begin n_err++; $display("FAIL miss_next_fire d2 got %0d exp 2", first_y(2, 16)); end
    endtask

    task automatic test_truncate();
        clear_stim();
        set_pulse(0, 3, 6); set_pulse(1, 3, 6);
        drive_gamma(7);
        n_vec += 1;
        if (count_y(0, 7) !== 4) begin n_err++; $display("FAIL trunc_width d0 got %0d exp 4", count_y(0, 7)); end
        clear_stim();
        set_pulse(0, 0, 19); set_pulse(1, 0, 19);
        drive_gamma(20);
        n_vec += 3;
        if (ob_y[0][0] !== 1'b0) begin n_err++; $display("FAIL trunc_drop d0 got %b exp 0", ob_y[0][0]); end
        if (count_y(0, 20) !== 0) begin n_err++; $display("FAIL held_y d0 got %0d exp 0", count_y(0, 20)); end
        if (count_rej(0, 20) !== 0) begin n_err++; $display("FAIL held_rej d0 got %0d exp 0", count_rej(0, 20)); end
    endtask

    task automatic test_three_and_async_reset();
        clear_stim();
        set_pulse(0, 6, 9); set_pulse(1, 7, 9); set_pulse(2, 7, 9);
        drive_gamma(10);
        n_vec += 4;
        if (first_y(3, 10) !== 7) begin n_err++; $display("FAIL three_first d3 got %0d exp 7", first_y(3, 10)); end
        if (ob_t[3][7] !== 4'd6) begin n_err++; $display("FAIL three_tout d3 got %0d exp 6", ob_t[3][7]); end
        if (ob_y[3][9] !== 1'b1) begin n_err++; $display("FAIL three_hold d3 got %b exp 1", ob_y[3][9]); end
        if (ob_rej[0][7] !== 1'b1) begin n_err++; $display("FAIL spread1_rej d0 got %b exp 1", ob_rej[0][7]); end
        #2;
        grst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            n_vec += 3;
            if (y_w[d] !== 1'b0) begin n_err++; $display("FAIL areset_y d%0d got %b exp 0", d, y_w[d]); end
            if (rej_w[d] !== 1'b0) begin n_err++; $display("FAIL areset_rej d%0d got %b exp 0", d, rej_w[d]); end
            if (t_w[d] !== 4'd0) begin n_err++; $display("FAIL areset_t d%0d got %0d exp 0", d, t_w[d]); end
            last_t[d] = 0;
        end
        @(negedge aclk);
        @(negedge aclk);
        grst_n = 1'b1;
    endtask

    task automatic test_random(input int n_gamma);
        for (int gi = 0; gi < n_gamma; gi++) begin
            int len;
            int base;
            len  = 8 + int'($urandom % 20);
            base = 1 + int'($urandom % 12);
            clear_stim();
            for (int c = 0; c < 3; c++) begin
                if ($urandom % 4 == 0) set_pulse(c, 0, int'($urandom % 3));
                if ($urandom % 8 != 0) begin
                    int r;
                    int w;
                    r = base + int'($urandom % 3);
                    w = 1 + int'($urandom % 4);
                    set_pulse(c, r, r + w - 1);
                    if ($urandom % 3 == 0) set_pulse(c, r + w + 1, r + w + 2);
                end
            end
            drive_gamma(len);
            for (int d = 0; d < ND; d++) begin
                int arr[3];
                int dec_k;
                int kind;
                int tfire;
                arr   = '{-1, -1, -1};
                dec_k = -1;
                kind  = 0;
                tfire = 0;
                // Arrival time = gamma count at the sampling edge; decide once per gamma.
                for (int k = 1; k < len && dec_k < 0; k++) begin
                    int g;
                    int tmn;
                    int tmx;
                    int na;
                    g = (k - 1 > 15) ? 15 : k - 1;
                    tmn = 99; tmx = -1; na = 0;
                    for (int c = 0; c < nch[d]; c++) begin
                        if (arr[c] < 0 && s[c][k] && !s[c][k-1]) arr[c] = g;
                        if (arr[c] >= 0) begin
                            na++;
                            if (arr[c] < tmn) tmn = arr[c];
                            if (arr[c] > tmx) tmx = arr[c];
                        end
                    end
                    if (na == nch[d]) begin
                        dec_k = k;
                        kind  = (tmx - tmn <= tolv[d]) ? 1 : 2;
                        tfire = tmx;
                    end else if (na > 0 && g - tmn > tolv[d]) begin
                        dec_k = k; kind = 2;
                    end else if (g == 15) begin
                        dec_k = k; kind = 0;
                    end
                end
                for (int k = 0; k < len; k++) begin
                    logic       ey;
                    logic       er;
                    logic [3:0] et;
                    ey = (kind == 1 && k >= dec_k && k < dec_k + PW);
                    er = (kind == 2 && k >= dec_k);
                    et = (kind == 1 && k >= dec_k) ? 4'(tfire) : 4'(last_t[d]);
                    n_vec += 3;
                    if (ob_y[d][k] !== ey) begin n_err++; $display("FAIL rnd_y g%0d d%0d k%0d got %b exp %b", gi, d, k, ob_y[d][k], ey); end
                    if (ob_rej[d][k] !== er) begin n_err++; $display("FAIL rnd_rej g%0d d%0d k%0d got %b exp %b", gi, d, k, ob_rej[d][k], er); end
                    if (ob_t[d][k] !== et) begin n_err++; $display("FAIL rnd_t g%0d d%0d k%0d got %0d exp %0d", gi, d, k, ob_t[d][k], et); end
                end
                if (kind == 1) last_t[d] = tfire;
            end
        end
    endtask

    initial begin
        clear_stim();
        test_reset();
        test_simultaneous();
        test_early_reject();
        test_silent_miss();
        test_truncate();
        test_three_and_async_reset();
        test_random(40);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
